add_num_wr_stage: RTL and testbench
===================================

Name: add_num_wr_stage

Overview:
- Downstream stage of the add-num AFU datapath.
- Accepts 9-bit sum results from the adder stage over a valid/ready handshake and buffers them in a small FIFO.
- Turns each result into a single-beat CCI-P c1 memory write to consecutive cache lines starting at a CSR-programmed base address, throttled by c1TxAlmFull.
- Counts write responses and pulses done once every programmed write is acknowledged.

Parameters:
- FIFO_DEPTH, 4, result buffer entries; power of two, ≥2.
- RES_W, 9, result width (8-bit operand sum plus carry).
- CNT_W, 16, width of the job length and counters.

Ports:
- clk  in  1  pClk from host_ccip.clk.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a job.
- cfg_base_addr  in  42  cache-line address of the first write (t_ccip_clAddr).
- cfg_num  in  CNT_W  number of results/writes in the job.
- res_valid  in  1  adder result valid.
- res_data  in  RES_W  adder result.
- res_ready  out  1  stage can accept a result.
- c1_valid  out  1  c1 write request valid (drives sTx.c1.valid).
- c1_addr  out  42  write address (hdr.address).
- c1_sop  out  1  start of packet (hdr.sop).
- c1_data  out  512  write data line.
- c1_alm_full  in  1  sRx.c1TxAlmFull.
- c1_rsp_valid  in  1  sRx.c1.rspValid; one per write (single-beat, no packing).
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job completion.
- wr_count  out  CNT_W  writes issued in the current/last job.

Behaviour:
- Reset (async assert, sync deassert by the system): state=IDLE; FIFO empty; all counters 0. Outputs: c1_valid=0, c1_addr=0, c1_sop=0, c1_data=0, busy=0, done=0, res_ready=0, wr_count=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start: latch cfg_base_addr into next_addr and cfg_num into remaining; clear wr_count and rsp_count.
  - If cfg_num==0, go to DONE; otherwise go to RUN.
  - start in any other state is ignored.
- res_ready = (state==RUN) && !fifo_full && (accepted < num).
  - Registered-independent of the same-cycle pop: a full FIFO never accepts, even while popping.
  - Accept occurs when res_valid && res_ready.
- Issue, evaluated every cycle in RUN and DRAIN:
  - If FIFO non-empty, !c1_alm_full and wr_count<num: next cycle c1_valid=1, c1_addr=next_addr, c1_sop=1, c1_data={zeros, result} with result in bits [RES_W-1:0]. Pop the FIFO, then next_addr+=1 and wr_count+=1.
  - Otherwise c1_valid=0 next cycle.
  - c1_valid is high for exactly one cycle per write; header and data are held only while c1_valid is high.
- Latency: an accepted result reaches c1_valid ≥2 cycles later (FIFO write, then registered issue).
- c1_alm_full gating:
  - Sampled in the same cycle the issue decision is made; the request is still driven the following cycle.
  - This matches the CCI-P almost-full slack; no outstanding-request limit beyond that.
- Address: next_addr increments modulo 2^42; wrap to 0 is permitted and not flagged.
- RUN→DRAIN when wr_count==num, i.e. all writes issued.
- DRAIN→DONE when rsp_count==num.
- rsp_count increments on every c1_rsp_valid in RUN or DRAIN. A c1_rsp_valid in the same cycle as an issue is counted normally.
- DONE: done=1 for one cycle, then IDLE. busy=1 in RUN and DRAIN only.
- c1_rsp_valid in IDLE/DONE: ignored, no counter change.
- res_valid outside RUN: not accepted (res_ready=0); upstream holds.
- Reset mid-job: all state discarded immediately. Outstanding responses arriving after reset are ignored because the stage is in IDLE.
- All counters are CNT_W bits wide. cfg_num is at most 2^CNT_W-1, so no overflow.

Decomposition:
- Shared package add_num_pkg:
  - t_wr_state enum (logic [1:0]).
  - CL_DATA_W=512 and CL_ADDR_W=42 constants.
  - t_res typedef (logic [RES_W-1:0] default).
- Sub-module add_num_res_fifo:
  - Synchronous FIFO, FIFO_DEPTH×RES_W.
  - Ports: push, push_data, pop, pop_data, full, empty, async active-low reset.
  - First-word fall-through on pop_data.

Test Plan:
- Basic job: start, base=0x100, num=3; results 0x0C, 0x1FE, 0x00; no alm_full; responses 2 cycles after each write -> writes to 0x100/0x101/0x102 with data[8:0]=0x0C/0x1FE/0x000, all upper bits 0; done pulses once; wr_count=3; busy low after.
- Backpressure: num=6; hold c1_alm_full=1 for 20 cycles while results stream -> exactly 4 results accepted, then res_ready=0 and no c1_valid; release -> 6 in-order writes to base..base+5, done after the 6th response.
- Zero-length: start with num=0 -> no c1_valid; done pulses within 2 cycles; busy never asserts.
- Late responses: num=2; withhold c1_rsp_valid 50 cycles after both writes -> state DRAIN, busy=1, done=0; two responses -> done next cycle.
- Address wrap: base=0x3FF_FFFF_FFFF, num=2 -> writes to 0x3FFFFFFFFFF then 0x0.
- Reset mid-job: assert reset_n=0 after 1 of 4 writes -> all outputs 0 asynchronously; after release a stray c1_rsp_valid causes no done; a new start with num=1 completes normally.

Source files
------------

// File: rtl/add_num_pkg.sv
// Shared types and constants for the add-num write stage.
package add_num_pkg;
  localparam int CL_DATA_W = 512;
  localparam int CL_ADDR_W = 42;
  localparam int RES_W_DEF = 9;

  typedef logic [RES_W_DEF-1:0] t_res;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } t_wr_state;
endpackage

// File: rtl/add_num_wr_stage_if.sv
// Result handshake from the adder plus the CCI-P c1 write channel.
interface add_num_wr_stage_if #(
  parameter int RES_W = 9
);
  import add_num_pkg::*;

  logic                 res_valid;
  logic [RES_W-1:0]     res_data;
  logic                 res_ready;
  logic                 c1_valid;
  logic [CL_ADDR_W-1:0] c1_addr;
  logic                 c1_sop;
  logic [CL_DATA_W-1:0] c1_data;
  logic                 c1_alm_full;
  logic                 c1_rsp_valid;

  // slave: the write stage; master: adder result source plus host side
  modport slave (
    input  res_valid, res_data, c1_alm_full, c1_rsp_valid,
    output res_ready, c1_valid, c1_addr, c1_sop, c1_data
  );
  modport master (
    output res_valid, res_data, c1_alm_full, c1_rsp_valid,
    input  res_ready, c1_valid, c1_addr, c1_sop, c1_data
  );
endinterface

// File: rtl/add_num_res_fifo.sv
// Small result buffer; pop_data shows the head entry without a read cycle.
module add_num_res_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int RES_W      = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [RES_W-1:0] push_data,
  input  logic             pop,
  output logic [RES_W-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [RES_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  // extra pointer bit distinguishes full from empty when indices match
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // storage needs no reset; only the pointers define occupancy
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // pointer advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/add_num_wr_stage.sv
// Buffers adder results and writes each one to consecutive cache lines.
module add_num_wr_stage
  import add_num_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RES_W      = 9,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [CL_ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]     cfg_num,
  add_num_wr_stage_if.slave    bus,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     wr_count
);
  t_wr_state            state_q, state_d;
  logic [CL_ADDR_W-1:0] next_addr;
  logic [CNT_W-1:0]     num_q, accepted, wr_cnt_q, rsp_cnt_q;
  logic [RES_W-1:0]     fifo_head;
  logic                 fifo_full, fifo_empty;
  logic                 active, accept, issue, rsp;

  assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  // ready never depends on this cycle's pop, so a full buffer always stalls
  assign bus.res_ready = (state_q == ST_RUN) && !fifo_full && (accepted < num_q);
  assign accept = bus.res_valid && bus.res_ready;
  // almost-full is honoured at decision time; the request still goes out next cycle
  assign issue  = active && !fifo_empty && !bus.c1_alm_full && (wr_cnt_q < num_q);
  assign rsp    = active && bus.c1_rsp_valid;

  assign busy     = active;
  assign done     = (state_q == ST_DONE);
  assign wr_count = wr_cnt_q;

  add_num_res_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .RES_W(RES_W)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (accept),
    .push_data (bus.res_data),
    .pop       (issue),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // job sequencing: issue everything, then wait for every acknowledgement
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = (cfg_num == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (wr_cnt_q == num_q) state_d = ST_DRAIN;
      ST_DRAIN: if (rsp_cnt_q == num_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // job counters and write address; start only takes effect in IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_addr <= '0;
      num_q     <= '0;
      accepted  <= '0;
      wr_cnt_q  <= '0;
      rsp_cnt_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      next_addr <= cfg_base_addr;
      num_q     <= cfg_num;
      accepted  <= '0;
      wr_cnt_q  <= '0;
      rsp_cnt_q <= '0;
    end else begin
      if (accept) accepted <= accepted + 1'b1;
      if (issue) begin
        next_addr <= next_addr + 1'b1;   // wraps modulo 2^42 by design
        wr_cnt_q  <= wr_cnt_q + 1'b1;
      end
      if (rsp) rsp_cnt_q <= rsp_cnt_q + 1'b1;
    end
  end

  // registered c1 request: one cycle per write, fields zero when idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.c1_valid <= 1'b0;
      bus.c1_addr  <= '0;
      bus.c1_sop   <= 1'b0;
      bus.c1_data  <= '0;
    end else begin
      bus.c1_valid <= issue;
      bus.c1_addr  <= issue ? next_addr : '0;
      bus.c1_sop   <= issue;
      bus.c1_data  <= issue ? {{(CL_DATA_W-RES_W){1'b0}}, fifo_head} : '0;
    end
  end
endmodule

// File: tb/tb_add_num_wr_stage.sv
// Randomized self-checking bench for the add-num write stage.
module tb_add_num_wr_stage;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [41:0] cfg_base_addr = '0;
  logic [15:0] cfg_num = '0;
  logic        busy, done;
  logic [15:0] wr_count;

  add_num_wr_stage_if #(.RES_W(9)) bus();

  add_num_wr_stage #(.FIFO_DEPTH(4), .RES_W(9), .CNT_W(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_num       (cfg_num),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .wr_count      (wr_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // observed-write log and host response model
  logic [41:0]  wr_addr_q[$];
  logic [511:0] wr_data_q[$];
  int rsp_due[$];
  int cyc = 0, done_cnt = 0, busy_cnt = 0, sop_bad = 0;
  bit rsp_auto = 1'b1, rsp_force = 1'b0, hit;

  // host: answer every write two cycles later; record what the DUT issued
  always begin
    @(posedge clk);
    cyc++;
    #1;
    hit = 1'b0;
    if (rsp_due.size() > 0) begin
      if (rsp_due[0] <= cyc) begin
        hit = 1'b1;
        void'(rsp_due.pop_front());
      end
    end
    bus.c1_rsp_valid = hit || rsp_force;
    if (bus.c1_valid === 1'b1) begin
      wr_addr_q.push_back(bus.c1_addr);
      wr_data_q.push_back(bus.c1_data);
      if (bus.c1_sop !== 1'b1) sop_bad++;
      if (rsp_auto) rsp_due.push_back(cyc + 2);
    end
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic start_job(input logic [41:0] base, input int n);
    @(negedge clk);
    cfg_base_addr = base;
    cfg_num = 16'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // offer results with random idle cycles (and optionally random almost-full)
  task automatic send_results(input logic [8:0] vals[$], input int idle_pct, input bit rand_alm);
    int i = 0, t = 0;
    while (i < vals.size() && t < 500) begin
      @(negedge clk);
      t++;
      bus.res_valid = ($urandom_range(99) >= idle_pct);
      bus.res_data  = vals[i];
      if (rand_alm) bus.c1_alm_full = ($urandom_range(3) == 0);
      if (bus.res_valid && bus.res_ready) i++;
    end
    @(negedge clk);
    bus.res_valid = 1'b0;
    bus.c1_alm_full = 1'b0;
    vectors++;
    if (i != vals.size()) begin
      miscompares++;
      $display("FAIL send_timeout accepted=%0d wanted=%0d", i, vals.size());
    end
  endtask

  task automatic wait_done(input int d0, input int bound);
    int t = 0;
    while (done_cnt == d0 && t < bound) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({bus.c1_valid, bus.c1_sop, busy, done, bus.res_ready} !== 5'b0 ||
        bus.c1_addr !== 42'd0 || bus.c1_data !== 512'd0 || wr_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_outputs valid=%b sop=%b busy=%b done=%b ready=%b wr_count=%0d want all zero",
               bus.c1_valid, bus.c1_sop, busy, done, bus.res_ready, wr_count);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || bus.res_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset busy=%b ready=%b want 0/0", busy, bus.res_ready);
    end
  endtask

  // shared shape for a normal job: drive, wait, compare against plain model
  task automatic test_job(input string name, input logic [41:0] base, input logic [8:0] vals[$],
                          input int idle_pct, input bit rand_alm);
    int d0 = done_cnt, w0 = wr_addr_q.size();
    logic [41:0] ea;
    start_job(base, vals.size());
    send_results(vals, idle_pct, rand_alm);
    wait_done(d0, 400);
    repeat (3) @(negedge clk);
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL %s_done_pulses got=%0d want=1", name, done_cnt - d0);
    end
    vectors++;
    if (wr_addr_q.size() - w0 != vals.size()) begin
      miscompares++;
      $display("FAIL %s_write_count got=%0d want=%0d", name, wr_addr_q.size() - w0, vals.size());
    end else begin
      for (int i = 0; i < vals.size(); i++) begin
        ea = base + 42'(i);
        vectors++;
        if (wr_addr_q[w0+i] !== ea || wr_data_q[w0+i] !== 512'(vals[i])) begin
          miscompares++;
          $display("FAIL %s_write%0d addr=%h data=%h want addr=%h data=%h",
                   name, i, wr_addr_q[w0+i], wr_data_q[w0+i][15:0], ea, vals[i]);
        end
      end
    end
    vectors++;
    if (wr_count !== 16'(vals.size()) || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_final wr_count=%0d busy=%b want %0d/0", name, wr_count, busy, vals.size());
    end
  endtask

  task automatic test_basic();
    logic [8:0] v[$];
    v = '{9'h00C, 9'h1FE, 9'h000};
    test_job("basic", 42'h100, v, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [8:0] v[$];
    logic [41:0] base;
    for (int k = 0; k < 4; k++) begin
      v.delete();
      for (int i = 0; i < int'($urandom_range(10, 1)); i++) v.push_back(9'($urandom));
      base = {10'($urandom), 32'($urandom)};
      test_job("random", base, v, 30, 1'b1);
    end
  endtask

  task automatic test_wrap();
    logic [8:0] v[$];
    v = '{9'($urandom), 9'($urandom)};
    test_job("wrap", 42'h3FF_FFFF_FFFF, v, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [8:0] v[$], rem[$];
    int acc = 0, d0 = done_cnt, w0 = wr_addr_q.size();
    for (int i = 0; i < 6; i++) v.push_back(9'($urandom));
    bus.c1_alm_full = 1'b1;
    start_job(42'h2000, 6);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      bus.res_valid = 1'b1;
      bus.res_data  = v[acc];
      if (bus.res_ready && acc < 5) acc++;
    end
    @(negedge clk);
    bus.res_valid = 1'b0;
    vectors++;
    if (acc != 4 || bus.res_ready !== 1'b0 || wr_addr_q.size() != w0) begin
      miscompares++;
      $display("FAIL bp_stall accepted=%0d ready=%b writes=%0d want 4/0/0",
               acc, bus.res_ready, wr_addr_q.size() - w0);
    end
    for (int i = 4; i < 6; i++) rem.push_back(v[i]);
    bus.c1_alm_full = 1'b0;
    send_results(rem, 0, 1'b0);
    wait_done(d0, 200);
    vectors++;
    if (done_cnt - d0 != 1 || wr_addr_q.size() - w0 != 6) begin
      miscompares++;
      $display("FAIL bp_complete done=%0d writes=%0d want 1/6", done_cnt - d0, wr_addr_q.size() - w0);
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (wr_addr_q[w0+i] !== 42'h2000 + 42'(i) || wr_data_q[w0+i] !== 512'(v[i])) begin
          miscompares++;
          $display("FAIL bp_write%0d addr=%h data=%h want addr=%h data=%h",
                   i, wr_addr_q[w0+i], wr_data_q[w0+i][15:0], 42'h2000 + 42'(i), v[i]);
        end
      end
    end
  endtask

  task automatic test_zero_length();
    int d0 = done_cnt, b0 = busy_cnt, w0 = wr_addr_q.size();
    start_job(42'h55, 0);
    repeat (3) @(negedge clk);
    vectors++;
    if (done_cnt - d0 != 1 || busy_cnt != b0 || wr_addr_q.size() != w0) begin
      miscompares++;
      $display("FAIL zero_len done=%0d busy_cycles=%0d writes=%0d want 1/0/0",
               done_cnt - d0, busy_cnt - b0, wr_addr_q.size() - w0);
    end
  endtask

  task automatic test_late_responses();
    logic [8:0] v[$];
    int d0 = done_cnt, w0 = wr_addr_q.size(), t = 0;
    v = '{9'($urandom), 9'($urandom)};
    rsp_auto = 1'b0;
    start_job(42'h900, 2);
    send_results(v, 0, 1'b0);
    while (wr_addr_q.size() - w0 < 2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (50) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || done_cnt != d0 || wr_addr_q.size() - w0 != 2) begin
      miscompares++;
      $display("FAIL late_drain busy=%b done=%b pulses=%0d writes=%0d want 1/0/0/2",
               busy, done, done_cnt - d0, wr_addr_q.size() - w0);
    end
    rsp_force = 1'b1;
    repeat (2) @(negedge clk);
    rsp_force = 1'b0;
    wait_done(d0, 6);
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL late_done pulses=%0d want=1", done_cnt - d0);
    end
    rsp_auto = 1'b1;
  endtask

  task automatic test_reset_mid_job();
    logic [8:0] v[$];
    int d0, w0 = wr_addr_q.size(), t = 0;
    v = '{9'($urandom)};
    start_job(42'h700, 4);
    send_results(v, 0, 1'b0);
    while (wr_addr_q.size() == w0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.c1_valid, bus.c1_sop, busy, done, bus.res_ready} !== 5'b0 ||
        bus.c1_addr !== 42'd0 || bus.c1_data !== 512'd0 || wr_count !== 16'd0) begin
      miscompares++;
      $display("FAIL async_reset valid=%b sop=%b busy=%b done=%b ready=%b wr_count=%0d want all zero",
               bus.c1_valid, bus.c1_sop, busy, done, bus.res_ready, wr_count);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    rsp_force = 1'b1;
    @(negedge clk);
    rsp_force = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stray_rsp pulses=%0d busy=%b want 0/0", done_cnt - d0, busy);
    end
    v = '{9'h1A5};
    test_job("post_reset", 42'hABC, v, 0, 1'b0);
    vectors++;
    if (sop_bad != 0) begin
      miscompares++;
      $display("FAIL sop_flag writes_without_sop=%0d want=0", sop_bad);
    end
  endtask

  initial begin
    bus.res_valid   = 1'b0;
    bus.res_data    = '0;
    bus.c1_alm_full = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_length();
    test_late_responses();
    test_wrap();
    test_random();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
